// File: rtl/apb_regfile_slave_pkg.sv
// Shared types and bus-width constants for the APB register-file completer.
package apb_regfile_slave_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } apb_slv_state_t;

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB3 bus bundle between the bridge (master) and one completer (slave).
interface apb_regfile_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB3 completer: read-only ID word at index 0, R/W words above it, programmable wait
// states and pslverr on misaligned, out-of-range or ID-write accesses.
module apb_regfile_slave
  import apb_regfile_slave_pkg::*;
#(
  parameter int unsigned       ADDR_W      = APB_ADDR_W,
  parameter int unsigned       DATA_W      = APB_DATA_W,
  parameter int unsigned       DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input logic               hclk,
  input logic               hreset,
  apb_regfile_slave_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  apb_slv_state_t state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              lat_write_q, lat_err_q;
  logic [IdxW-1:0]   lat_idx_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              setup, latch_en, commit, mem_we;
  logic              dec_err, c_write, c_err;
  logic [ADDR_W-1:0] off_word;
  logic [IdxW-1:0]   dec_idx, c_idx;
  logic [DATA_W-1:0] c_wdata, prdata_d;
  logic              pready_d, pslverr_d;

  assign setup    = bus.psel & ~bus.penable;
  assign off_word = (bus.paddr - BASE_ADDR) >> 2;
  assign dec_idx  = off_word[IdxW-1:0];
  assign dec_err  = (bus.paddr[1:0] != 2'b00) | (bus.paddr < BASE_ADDR) |
                    (off_word >= ADDR_W'(DEPTH)) | (bus.pwrite & (off_word == '0));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (setup) state_d = (WAIT_STATES == 0) ? StResp : StWait;
      StWait: begin
        if (!bus.psel)               state_d = StIdle;
        else if (wait_cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    commit     = 1'b0;
    latch_en   = 1'b0;
    wait_cnt_d = wait_cnt_q;
    c_write    = lat_write_q;
    c_err      = lat_err_q;
    c_idx      = lat_idx_q;
    c_wdata    = lat_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (setup) begin
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            c_write = bus.pwrite;
            c_err   = dec_err;
            c_idx   = dec_idx;
            c_wdata = bus.pwdata;
          end else begin
            latch_en   = 1'b1;
            wait_cnt_d = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        // Dropping psel mid-wait abandons the transfer without a response.
        if (!bus.psel) begin
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          commit     = (wait_cnt_q == 4'd1);
        end
      end
      default: wait_cnt_d = '0;
    endcase

    pready_d  = commit;
    pslverr_d = commit & c_err;
    mem_we    = commit & ~c_err & c_write;
    prdata_d  = bus.prdata;
    if (commit && c_err)              prdata_d = '0;
    else if (commit && !c_write)      prdata_d = (c_idx == '0) ? ID_VALUE : mem_q[c_idx];
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wait_cnt_q  <= '0;
      lat_write_q <= 1'b0;
      lat_err_q   <= 1'b0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
      bus.prdata  <= '0;
      bus.pready  <= 1'b0;
      bus.pslverr <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      bus.prdata  <= prdata_d;
      bus.pready  <= pready_d;
      bus.pslverr <= pslverr_d;
      if (latch_en) begin
        lat_write_q <= bus.pwrite;
        lat_err_q   <= dec_err;
        lat_idx_q   <= dec_idx;
        lat_wdata_q <= bus.pwdata;
      end
      if (mem_we) mem_q[c_idx] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: three completers (0, 1 and 3 wait states) share one APB master model.
module tb_apb_regfile_slave;

  localparam logic [31:0] B  = 32'h4000_1000;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  int          dsel = 0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  int          n_checks = 0, n_pass = 0;

  always #5 hclk = ~hclk;

  apb_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  apb_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  apb_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  assign bus0.psel = psel && (dsel == 0);
  assign bus1.psel = psel && (dsel == 1);
  assign bus2.psel = psel && (dsel == 2);
  assign bus0.penable = penable;
  assign bus1.penable = penable;
  assign bus2.penable = penable;
  assign bus0.pwrite = pwrite;
  assign bus1.pwrite = pwrite;
  assign bus2.pwrite = pwrite;
  assign bus0.paddr = paddr;
  assign bus1.paddr = paddr;
  assign bus2.paddr = paddr;
  assign bus0.pwdata = pwdata;
  assign bus1.pwdata = pwdata;
  assign bus2.pwdata = pwdata;

  always_comb begin
    case (dsel)
      1:       begin prdata = bus1.prdata; pready = bus1.pready; pslverr = bus1.pslverr; end
      2:       begin prdata = bus2.prdata; pready = bus2.pready; pslverr = bus2.pslverr; end
      default: begin prdata = bus0.prdata; pready = bus0.pready; pslverr = bus0.pslverr; end
    endcase
  end

  apb_regfile_slave #(.BASE_ADDR(B), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .bus(bus0));
  apb_regfile_slave #(.BASE_ADDR(B), .WAIT_STATES(1)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .bus(bus1));
  apb_regfile_slave #(.BASE_ADDR(B), .WAIT_STATES(3)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .bus(bus2));

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Called at posedge+1 with the bus idle; returns at posedge+1 with the bus idle again,
  // so consecutive calls are back-to-back transfers.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd,
                      output logic err, output int waits);
    dsel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    waits = 0;
    @(negedge hclk);
    check("setup_pready", {31'b0, pready}, 32'd0);
    @(posedge hclk); #1;
    penable = 1'b1;
    forever begin
      @(negedge hclk);
      if (pready) break;
      waits++;
      if (waits > 40) begin
        n_checks++;
        $display("FAIL xfer_timeout: got no pready want pready within 40 cycles");
        break;
      end
    end
    rd = prdata; err = pslverr;
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input int d, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic        err;
    int          w;
    xfer(d, wr, addr, wdata, rd, err, w);
    check({tag, "_waits"}, w, exp_waits);
    check({tag, "_pslverr"}, {31'b0, err}, {31'b0, exp_err});
    if (!wr) check({tag, "_prdata"}, rd, exp_rd);
  endtask

  initial begin
    vecs[0]  = '{1, 1'b0, B + 32'h0,  32'h0,         ID,            1'b0, 1};
    vecs[1]  = '{1, 1'b1, B + 32'h8,  32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    vecs[2]  = '{1, 1'b0, B + 32'h8,  32'h0,         32'hDEAD_BEEF, 1'b0, 1};
    vecs[3]  = '{0, 1'b1, B + 32'h8,  32'hDEAD_BEEF, 32'h0,         1'b0, 0};
    vecs[4]  = '{0, 1'b0, B + 32'h8,  32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[5]  = '{2, 1'b1, B + 32'h8,  32'hDEAD_BEEF, 32'h0,         1'b0, 3};
    vecs[6]  = '{2, 1'b0, B + 32'h8,  32'h0,         32'hDEAD_BEEF, 1'b0, 3};
    vecs[7]  = '{1, 1'b1, B + 32'h0,  32'h1234_5678, 32'h0,         1'b1, 1};
    vecs[8]  = '{1, 1'b0, B + 32'h0,  32'h0,         ID,            1'b0, 1};
    vecs[9]  = '{1, 1'b0, B + 32'h40, 32'h0,         32'h0,         1'b1, 1};
    vecs[10] = '{1, 1'b0, B + 32'h6,  32'h0,         32'h0,         1'b1, 1};
    vecs[11] = '{1, 1'b0, B - 32'h4,  32'h0,         32'h0,         1'b1, 1};
    vecs[12] = '{1, 1'b0, B + 32'h8,  32'h0,         32'hDEAD_BEEF, 1'b0, 1};
    vecs[13] = '{1, 1'b1, B + 32'h3C, 32'hCAFE_F00D, 32'h0,         1'b0, 1};
    vecs[14] = '{1, 1'b0, B + 32'h3C, 32'h0,         32'hCAFE_F00D, 1'b0, 1};
    vecs[15] = '{0, 1'b0, B + 32'h3C, 32'h0,         32'h0,         1'b0, 0};

    repeat (3) @(posedge hclk);
    for (int d = 0; d < 3; d++) begin
      dsel = d;
      @(negedge hclk);
      check($sformatf("rst%0d_pready", d), {31'b0, pready}, 32'd0);
      check($sformatf("rst%0d_pslverr", d), {31'b0, pslverr}, 32'd0);
      check($sformatf("rst%0d_prdata", d), prdata, 32'd0);
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;

    for (int i = 0; i < 16; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].rdata, vecs[i].err, vecs[i].waits);

    // Abort: psel dropped while the 3-wait completer is still stalling a write.
    dsel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = B + 32'h4;
    pwdata = 32'h0000_0055;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(negedge hclk);
    check("abort_access_pready", {31'b0, pready}, 32'd0);
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      check($sformatf("abort_idle%0d_pready", i), {31'b0, pready}, 32'd0);
    end
    @(posedge hclk); #1;
    run_xfer("abort_rd", 2, 1'b0, B + 32'h4, 32'h0, 32'h0, 1'b0, 3);

    // penable without a preceding setup phase must be ignored.
    dsel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = B + 32'h10;
    pwdata = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      check($sformatf("nosetup%0d_pready", i), {31'b0, pready}, 32'd0);
    end
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
    run_xfer("nosetup_rd", 0, 1'b0, B + 32'h10, 32'h0, 32'h0, 1'b0, 0);

    // Back-to-back transfers as the bridge issues them for a burst.
    run_xfer("b2b_w4", 1, 1'b1, B + 32'h4, 32'h1111_1111, 32'h0, 1'b0, 1);
    run_xfer("b2b_w8", 1, 1'b1, B + 32'h8, 32'h2222_2222, 32'h0, 1'b0, 1);
    run_xfer("b2b_r4", 1, 1'b0, B + 32'h4, 32'h0, 32'h1111_1111, 1'b0, 1);
    run_xfer("b2b_r8", 1, 1'b0, B + 32'h8, 32'h0, 32'h2222_2222, 1'b0, 1);

    // Reset asserted in the access phase of a write.
    dsel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = B + 32'hC;
    pwdata = 32'h0000_ABCD;
    @(posedge hclk); #1;
    penable = 1'b1;
    #2 hreset = 1'b1;
    #1;
    check("midrst_pready", {31'b0, pready}, 32'd0);
    check("midrst_pslverr", {31'b0, pslverr}, 32'd0);
    check("midrst_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;
    run_xfer("midrst_rd3", 1, 1'b0, B + 32'hC, 32'h0, 32'h0, 1'b0, 1);
    run_xfer("midrst_rd2", 1, 1'b0, B + 32'h8, 32'h0, 32'h0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
